// File: rtl/loader_pkg.sv
// Shared constants for the serial instruction-memory loader: FSM and RX state
// encodings plus the frame sync byte.
package loader_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEN   = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_CHK   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERROR = 3'd5;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, falling-edge start detect with a
// mid-bit glitch filter, LSB-first data capture and stop-bit check.
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TMR_W-1:0] HALF_BIT = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] FULL_BIT = TMR_W'(CLKS_PER_BIT - 1);

   logic             rx_meta, rx_sync, rx_prev;
   logic [1:0]       rx_state;
   logic [TMR_W-1:0] timer;
   logic [2:0]       bit_idx;

   // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= RX_IDLE;
         timer      <= '0;
         bit_idx    <= '0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               // Only a genuine high-to-low edge starts a frame, never a line stuck low.
               if (rx_prev && !rx_sync) begin
                  rx_state <= RX_START;
                  timer    <= '0;
               end
            end
            RX_START: begin
               if (timer == HALF_BIT) begin
                  timer    <= '0;
                  bit_idx  <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RX_DATA: begin
               if (timer == FULL_BIT) begin
                  timer     <= '0;
                  byte_data <= {rx_sync, byte_data[7:1]};
                  bit_idx   <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RX_STOP: begin
               if (timer == FULL_BIT) begin
                  timer      <= '0;
                  rx_state   <= RX_IDLE;
                  byte_valid <= rx_sync;
                  frame_err  <= !rx_sync;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/imem_uart_loader.sv
// Serial program loader: turns A5/N/data[/chk] UART frames into imem writes and
// holds the CPU while loading. Define LOADER_CHECKSUM_EN for the trailing XOR byte.
module imem_uart_loader
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 434,
   parameter int ADDR_W         = 7,
   parameter int TIMEOUT_CYCLES = 2000000
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              uart_rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic             byte_valid, frame_err;
   logic [7:0]       byte_data;
   logic [2:0]       state;
   logic [CNT_W-1:0] n_words, wl_next;
   logic [1:0]       byte_idx;
   logic [23:0]      word_sh;
   logic [TMO_W-1:0] tmo;
   logic             in_frame;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       chk_acc;
`endif

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clock      (clock),
      .reset      (reset),
      .rx         (uart_rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   assign in_frame = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
   assign wl_next  = (words_loaded == MAX_WORDS) ? words_loaded : words_loaded + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_hold     <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
         words_loaded <= '0;
         n_words      <= '0;
         byte_idx     <= '0;
         word_sh      <= '0;
         tmo          <= '0;
`ifdef LOADER_CHECKSUM_EN
         chk_acc      <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
         tmo     <= (in_frame && !byte_valid) ? tmo + 1'b1 : '0;

         if (imem_we) begin
            // Write cycle just ended: advance the pointer and decide whether the frame body is over.
            words_loaded <= wl_next;
            if (imem_addr != '1) imem_addr <= imem_addr + 1'b1;
            if (wl_next == n_words) begin
`ifdef LOADER_CHECKSUM_EN
               state     <= ST_CHK;
`else
               state     <= ST_DONE;
               load_done <= 1'b1;
               cpu_hold  <= 1'b0;
`endif
            end
         end else if (frame_err) begin
            if (in_frame) begin
               state      <= ST_ERROR;
               load_error <= 1'b1;
            end
         end else if (byte_valid) begin
            case (state)
               ST_IDLE, ST_DONE, ST_ERROR: begin
                  if (byte_data == SYNC_BYTE) begin
                     state        <= ST_LEN;
                     cpu_hold     <= 1'b1;
                     load_done    <= 1'b0;
                     load_error   <= 1'b0;
                     words_loaded <= '0;
                     imem_addr    <= '0;
                     byte_idx     <= '0;
                  end
               end
               ST_LEN: begin
                  if (byte_data == 8'd0 || int'(byte_data) > (1 << ADDR_W)) begin
                     state      <= ST_ERROR;
                     load_error <= 1'b1;
                  end else begin
                     n_words   <= CNT_W'(byte_data);
                     imem_addr <= '0;
                     byte_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
                     chk_acc   <= '0;
`endif
                     state     <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  word_sh  <= {word_sh[15:0], byte_data};
                  byte_idx <= byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  chk_acc  <= chk_acc ^ byte_data;
`endif
                  if (byte_idx == 2'd3) begin
                     imem_wdata <= {word_sh, byte_data};
                     imem_we    <= 1'b1;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               ST_CHK: begin
                  if (byte_data == chk_acc) begin
                     state     <= ST_DONE;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     state      <= ST_ERROR;
                     load_error <= 1'b1;
                  end
               end
`endif
               default: state <= ST_IDLE;
            endcase
         end else if (in_frame && tmo == TMO_LAST) begin
            state      <= ST_ERROR;
            load_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: directed UART frames, expected imem
// writes queued by the stimulus and popped by an independent write monitor.
module tb_imem_uart_loader;

   localparam int CPB    = 8;
   localparam int ADDR_W = 7;
   localparam int TMO    = 400;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              uart_rx = 1'b1;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_error;
   logic [ADDR_W:0]   words_loaded;

   int          n_checks = 0;
   int          n_errors = 0;
   int          bv_cnt   = 0;
   wr_t         exp_q[$];
   logic [7:0]  tx_xor;

   imem_uart_loader #(
      .CLKS_PER_BIT   (CPB),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .uart_rx      (uart_rx),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (dut.u_rx.byte_valid) bv_cnt <= bv_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest queued expectation.
   initial begin
      wr_t e;
      forever begin
         @(negedge clock);
         if (!reset && imem_we) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                        imem_addr, imem_wdata);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 32'(imem_addr), 32'(e.addr));
               check("write_data", imem_wdata, e.data);
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      uart_rx = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         wait_cycles(CPB);
      end
      uart_rx = stop_bit;
      wait_cycles(CPB);
      uart_rx = 1'b1;
      wait_cycles(2 * CPB);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) begin
         send_byte(w[8*i +: 8]);
         tx_xor ^= w[8*i +: 8];
      end
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic start_frame(input logic [7:0] n);
      send_byte(8'hA5);
      send_byte(n);
      tx_xor = 8'h00;
   endtask

   task automatic end_frame();
`ifdef LOADER_CHECKSUM_EN
      send_byte(tx_xor);
`endif
      wait_cycles(4);
   endtask

   task automatic check_status(input string tag, input logic done, input logic err,
                               input logic hold, input int wl);
      check({tag, "_load_done"}, 32'(load_done), 32'(done));
      check({tag, "_load_error"}, 32'(load_error), 32'(err));
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(hold));
      check({tag, "_words_loaded"}, 32'(words_loaded), 32'(wl));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
      check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
      check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
      check_status(tag, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      int bv_snap;
      wait_cycles(4);
      check_all_zero("reset");
      reset = 1'b0;
      wait_cycles(3 * CPB);

      // 1: two-word load
      push_exp(7'd0, 32'h20080005);
      push_exp(7'd1, 32'hAC090001);
      start_frame(8'h02);
      send_word(32'h20080005);
      send_word(32'hAC090001);
      end_frame();
      check_status("t1", 1'b1, 1'b0, 1'b0, 2);

      // 2: junk ahead of sync is ignored
      send_byte(8'h3C);
      send_byte(8'h7F);
      check_status("t2_junk", 1'b1, 1'b0, 1'b0, 2);
      push_exp(7'd0, 32'h11223344);
      start_frame(8'h01);
      check("t2_hold_during_load", 32'(cpu_hold), 32'd1);
      send_word(32'h11223344);
      end_frame();
      check_status("t2", 1'b1, 1'b0, 1'b0, 1);

      // 3: zero length, then a retry
      send_byte(8'hA5);
      send_byte(8'h00);
      wait_cycles(4);
      check_status("t3_zero_len", 1'b0, 1'b1, 1'b1, 0);
      push_exp(7'd0, 32'hDEADBEEF);
      start_frame(8'h01);
      send_word(32'hDEADBEEF);
      end_frame();
      check_status("t3_retry", 1'b1, 1'b0, 1'b0, 1);

      // 4a: framing error on the third data byte
      start_frame(8'h02);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03, 1'b0);
      wait_cycles(4);
      check_status("t4_framing", 1'b0, 1'b1, 1'b1, 0);

      // 4b: line goes quiet after the first word
      push_exp(7'd0, 32'h01020304);
      start_frame(8'h02);
      send_word(32'h01020304);
      wait_cycles(4);
      check_status("t4_mid_frame", 1'b0, 1'b0, 1'b1, 1);
      wait_cycles(TMO + 50);
      check_status("t4_timeout", 1'b0, 1'b1, 1'b1, 1);

      // 5a: short low glitch on an idle line
      bv_snap = bv_cnt;
      uart_rx = 1'b0;
      wait_cycles(2);
      uart_rx = 1'b1;
      wait_cycles(4 * CPB);
      check("t5_glitch_byte_valid", 32'(bv_cnt), 32'(bv_snap));
      check_status("t5_glitch", 1'b0, 1'b1, 1'b1, 1);

      // 5b: reset in the middle of a word, remaining bytes must not write
      start_frame(8'h02);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      check("t5_hold_before_reset", 32'(cpu_hold), 32'd1);
      reset = 1'b1;
      wait_cycles(1);
      check_all_zero("t5_reset");
      reset = 1'b0;
      send_byte(8'hDD);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      wait_cycles(4);
      check_all_zero("t5_after_reset");

`ifdef LOADER_CHECKSUM_EN
      // 6: bad checksum after two good words
      push_exp(7'd0, 32'h20080005);
      push_exp(7'd1, 32'hAC090001);
      start_frame(8'h02);
      send_word(32'h20080005);
      send_word(32'hAC090001);
      send_byte(8'h00);
      wait_cycles(4);
      check_status("t6_bad_chk", 1'b0, 1'b1, 1'b1, 2);
`endif

      wait_cycles(10);
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
